// File: rtl/seven_seg_scan_driver.sv
// Binary-to-BCD converter and 4-digit multiplexed 7-segment scan driver.
// Ports: clk, ck_rst, value/value_valid/busy (load), dp_mask, blank, seg/dp/an (pins).
module seven_seg_scan_driver #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SLOT_HZ        = 4_000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic        clk,
  input  logic        ck_rst,
  input  logic [13:0] value,
  input  logic        value_valid,
  input  logic [3:0]  dp_mask,
  input  logic        blank,
  output logic        busy,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int TICKS = CLK_HZ / SLOT_HZ;
  localparam int PW = (TICKS > 2) ? $clog2(TICKS) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV = (AN_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t state, state_nx;
  logic load, step, commit;

  logic [3:0]  iter;
  logic [29:0] sh;
  logic [15:0] adj;
  logic [15:0] disp;
  logic [13:0] sat;

  logic [PW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic [3:0]    lz;
  logic [6:0]    pat;
  logic [3:0]    oh;

  // Converter FSM
  always_ff @(posedge clk) begin
    if (ck_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (value_valid) state_nx = SHIFT;
      SHIFT:   if (iter == 4'd13) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    load   = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    unique case (state)
      IDLE:   load = value_valid;
      SHIFT:  begin busy = 1'b1; step = 1'b1; end
      COMMIT: begin busy = 1'b1; commit = 1'b1; end
      default: ;
    endcase
  end

  // Double-dabble: sh = {bcd[15:0], bin[13:0]}
  assign sat = (value > 14'd9999) ? 14'd9999 : value;

  always_comb begin
    adj = '0;
    for (int i = 0; i < 4; i++) begin
      if (sh[14+4*i +: 4] >= 4'd5) adj[4*i +: 4] = sh[14+4*i +: 4] + 4'd3;
      else                          adj[4*i +: 4] = sh[14+4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (ck_rst) begin
      sh   <= '0;
      iter <= '0;
      disp <= '0;
    end else begin
      if (load) begin
        sh   <= {16'd0, sat};
        iter <= '0;
      end else if (step) begin
        sh   <= {adj[14:0], sh[13:0], 1'b0};
        iter <= iter + 4'd1;
      end
      if (commit) disp <= sh[29:14];
    end
  end

  // Slot prescaler and digit index
  always_ff @(posedge clk) begin
    if (ck_rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  // A digit is blanked when it and every higher digit are zero
  always_comb begin
    lz[3] = (disp[15:12] == 4'd0);
    lz[2] = lz[3] && (disp[11:8] == 4'd0);
    lz[1] = lz[2] && (disp[7:4] == 4'd0);
    lz[0] = 1'b0;
  end

  always_comb begin
    nib = disp[4*idx +: 4];
    unique case (nib)
      4'd0:    pat = 7'b0111111;
      4'd1:    pat = 7'b0000110;
      4'd2:    pat = 7'b1011011;
      4'd3:    pat = 7'b1001111;
      4'd4:    pat = 7'b1100110;
      4'd5:    pat = 7'b1101101;
      4'd6:    pat = 7'b1111101;
      4'd7:    pat = 7'b0000111;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1101111;
      default: pat = 7'b0000000;
    endcase
    if ((BLANK_LEADING != 0) && lz[idx]) pat = 7'b0000000;
    oh = blank ? 4'b0000 : (4'b0001 << idx);
  end

  always_ff @(posedge clk) begin
    if (ck_rst) begin
      seg <= {7{SEG_INV}};
      dp  <= SEG_INV;
      an  <= {4{AN_INV}};
    end else begin
      seg <= pat ^ {7{SEG_INV}};
      dp  <= dp_mask[idx] ^ SEG_INV;
      an  <= oh ^ {4{AN_INV}};
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver.
// Sim params give 4 clocks per slot with active-low pins.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        ck_rst = 1'b1;
  logic [13:0] value = '0;
  logic        value_valid = 1'b0;
  logic [3:0]  dp_mask = '0;
  logic        blank = 1'b0;
  logic        busy;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  int n;

  seven_seg_scan_driver #(
    .CLK_HZ(100),
    .SLOT_HZ(25),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1),
    .BLANK_LEADING(1)
  ) dut (
    .clk(clk),
    .ck_rst(ck_rst),
    .value(value),
    .value_valid(value_valid),
    .dp_mask(dp_mask),
    .blank(blank),
    .busy(busy),
    .seg(seg),
    .dp(dp),
    .an(an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] a, input string tag);
    int k = 0;
    while (an !== a && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_an"}, {28'd0, an}, {28'd0, a});
  endtask

  task automatic dig(input logic [3:0] a, input logic [6:0] s,
                     input logic d, input string tag);
    wait_an(a, tag);
    chk({tag, "_seg"}, {25'd0, seg}, {25'd0, s});
    chk({tag, "_dp"}, {31'd0, dp}, {31'd0, d});
  endtask

  task automatic convert(input logic [13:0] v, input string tag);
    int k = 0;
    value = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    while (busy === 1'b1 && k < 40) begin
      k++;
      tick();
    end
    chk({tag, "_busylen"}, k, 15);
    tick();
  endtask

  initial begin
    // 1. reset
    tick(); tick(); tick();
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'h1);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    ck_rst = 1'b0;
    tick();
    chk("slot0_an", {28'd0, an}, 32'hE);
    chk("slot0_seg", {25'd0, seg}, 32'h40);
    tick(); tick(); tick(); tick();
    chk("slot1_an", {28'd0, an}, 32'hD);
    chk("slot1_seg", {25'd0, seg}, 32'h7F);

    // 2. 1234
    convert(14'd1234, "v1234");
    dig(4'b1110, 7'b0011001, 1'b1, "v1234_d0");
    dig(4'b1101, 7'b0110000, 1'b1, "v1234_d1");
    dig(4'b1011, 7'b0100100, 1'b1, "v1234_d2");
    dig(4'b0111, 7'b1111001, 1'b1, "v1234_d3");

    // 3. 7 with leading blanking and dp on digit 2
    dp_mask = 4'b0100;
    convert(14'd7, "v7");
    dig(4'b1110, 7'b1111000, 1'b1, "v7_d0");
    dig(4'b1101, 7'h7F, 1'b1, "v7_d1");
    dig(4'b1011, 7'h7F, 1'b0, "v7_d2");
    dig(4'b0111, 7'h7F, 1'b1, "v7_d3");
    dp_mask = 4'b0000;

    // 4. saturation
    convert(14'd12000, "sat");
    dig(4'b1110, 7'b0010000, 1'b1, "sat_d0");
    dig(4'b1101, 7'b0010000, 1'b1, "sat_d1");
    dig(4'b1011, 7'b0010000, 1'b1, "sat_d2");
    dig(4'b0111, 7'b0010000, 1'b1, "sat_d3");

    // 5. strobe while busy is ignored
    value = 14'd42;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    tick(); tick();
    chk("ign_busy", {31'd0, busy}, 32'h1);
    value = 14'd99;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("ign_done", {31'd0, busy}, 32'h0);
    tick(); tick(); tick();
    chk("ign_still_idle", {31'd0, busy}, 32'h0);
    dig(4'b1110, 7'b0100100, 1'b1, "v42_d0");
    dig(4'b1101, 7'b0011001, 1'b1, "v42_d1");
    dig(4'b1011, 7'h7F, 1'b1, "v42_d2");
    convert(14'd99, "v99");
    dig(4'b1110, 7'b0010000, 1'b1, "v99_d0");
    dig(4'b1101, 7'b0010000, 1'b1, "v99_d1");
    dig(4'b1011, 7'h7F, 1'b1, "v99_d2");

    // 6. reset aborts a conversion
    value = 14'd5678;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    chk("ab_busy1", {31'd0, busy}, 32'h1);
    tick(); tick(); tick(); tick(); tick();
    ck_rst = 1'b1;
    tick();
    ck_rst = 1'b0;
    chk("ab_busy", {31'd0, busy}, 32'h0);
    chk("ab_an", {28'd0, an}, 32'hF);
    tick();
    chk("ab_an0", {28'd0, an}, 32'hE);
    chk("ab_seg0", {25'd0, seg}, 32'h40);
    for (int i = 0; i < 20; i++) tick();
    chk("ab_idle", {31'd0, busy}, 32'h0);
    dig(4'b1110, 7'b1000000, 1'b1, "ab_d0");
    dig(4'b0111, 7'h7F, 1'b1, "ab_d3");

    // 7. blank mid-slot
    wait_an(4'b1110, "bl_sync0");
    wait_an(4'b1101, "bl_sync1");
    tick();
    blank = 1'b1;
    tick();
    chk("bl_off0", {28'd0, an}, 32'hF);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("bl_off%0d", i), {28'd0, an}, 32'hF);
    end
    blank = 1'b0;
    tick();
    chk("bl_resume", {28'd0, an}, 32'hB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
